uart_packet_arbiter: RTL
========================

# uart_packet_arbiter

Round-robin, packet-locked arbiter that shares the single transmit stream of the UART packet interface between up to eight requesters. Each requester presents `UART_PACKET` beats; the arbiter grants one requester from its SoP beat through its EoP beat and forwards the beats, unmodified, through a registered output stage into the UART packet transmitter. It sits directly in front of the UART packet block's `ipTxStream`/`opTxReady` pair.

## Interface
- `NUM_PORTS`, default 4: number of requesters, legal range 2..8.
- `ipClk`  in  1: system clock, all logic on the rising edge.
- `ipReset`  in  1: synchronous, active-low reset.
- `ipStream`  in  NUM_PORTS x UART_PACKET: requester beats; a beat is offered while its `.Valid` is 1.
- `opReady`  out  NUM_PORTS: per-requester accept; a beat transfers on a cycle where `ipStream[i].Valid` and `opReady[i]` are both 1.
- `opTxStream`  out  UART_PACKET: registered beat to the UART packet transmitter.
- `ipTxReady`  in  1: transmitter accept; an output beat transfers when `opTxStream.Valid` and `ipTxReady` are both 1.
- `opGrant`  out  NUM_PORTS: one-hot current owner; all zero when idle.
- `opBusy`  out  1: 1 while in STREAM.
- `opDropped`  out  1: one-cycle pulse when an orphan beat is discarded.

## Operation
- States: IDLE and STREAM.
- **IDLE**
  - Requesting ports are those with `Valid && SoP`.
  - Search starts at `(last + 1) mod NUM_PORTS`; the first requesting port wins.
  - On a win: register `opGrant`, go to STREAM next cycle, and set `last` to the winner.
  - `opReady` is 0 for all ports, except orphan draining below.
- **Orphan draining (IDLE only)**
  - An orphan is a port with `Valid && !SoP` that is not granted.
  - The lowest-index orphan is drained: `opReady` = 1 for one cycle, the beat is discarded, and `opDropped` = 1.
  - Orphan draining takes precedence over arbitration on that cycle.
- **STREAM**
  - `opReady[g] = !opTxStream.Valid || ipTxReady`; all other ports get 0.
  - An accepted beat loads the output register with every field copied unchanged.
  - When the output transfers with no new load, `opTxStream.Valid` clears.
  - When an EoP beat is accepted from the owner, go to IDLE on the next cycle and clear `opGrant`.
  - SoP on a mid-packet beat is forwarded unchanged; it is not checked.
- `Length` is not interpreted; only SoP and EoP bound ownership.
- Reset (ipReset = 0, sampled on an edge):
  - state = IDLE; `opGrant`, `opReady`, `opBusy`, `opDropped` = 0.
  - `opTxStream` = all zero, so `Valid` = 0.
  - `last` = NUM_PORTS-1, giving port 0 first priority.
  - A packet in flight is truncated and no EoP is emitted. Downstream recovers on the next SoP.

## Timing
- Arbitration latency:
  - Cycle 0: SoP request seen in IDLE.
  - Cycle 1: grant registered and first beat accepted.
  - Cycle 2: `opTxStream.Valid` = 1.
- Steady state: one beat per cycle while `ipTxReady` is held at 1.
- Packet gap: one IDLE cycle between the EoP acceptance of one packet and the SoP acceptance of the next. The output register may still hold the EoP beat during that cycle.
- Backpressure: with `opTxStream.Valid` = 1 and `ipTxReady` = 0, the output is held stable and `opReady[g]` = 0.
- Simultaneous events: a request arriving in the same cycle as the EoP acceptance is arbitrated in the following IDLE cycle.

## Structure
- `UART_PACKET` stays in the shared `Structures` package.
- Add an `ARB_STATE` enum (IDLE, STREAM) and `MAX_ARB_PORTS` = 8 to `Structures`.
- One combinational sub-module, `rr_picker`:
  - Inputs: request vector and `last` index.
  - Outputs: one-hot winner and a found flag.
  - Also reused for orphan selection, with `last` fixed at NUM_PORTS-1.

## Test plan
- Hold ipReset = 0 for 3 cycles with all ports valid -> `opTxStream.Valid`, `opGrant`, `opReady`, `opBusy` all 0. After release, port 0 wins first.
- Port 0 sends a single beat {Source 100, Destination 200, Length 1, Data 20, SoP 1, EoP 1} with `ipTxReady` = 1 -> identical beat on `opTxStream` at cycle 2, `opGrant` = 0001 for one cycle, then 0000.
- Ports 0 and 2 each send 3-beat packets starting together -> port 0's data 1,2,3 forwarded contiguously, one gap cycle, then port 2's data 4,5,6. No interleaving.
- `ipTxReady` low for 5 cycles after the second beat -> `opTxStream` held stable and `opReady` = 0 throughout. No beat lost or duplicated.
- All 4 ports stream single-beat packets continuously -> grant order 0,1,2,3,0,1... Port 1 sends a non-SoP beat in IDLE -> drained with one `opDropped` pulse and never forwarded.
- Assert reset during beat 2 of a 4-beat packet -> outputs cleared next cycle. The next SoP from any port is forwarded normally.

Source files
------------

// File: rtl/Structures.sv
// Structures: shared UART packet beat type plus arbiter state and sizing constants
package Structures;
    localparam int MAX_ARB_PORTS = 8;
    localparam int ARB_IDX_W = $clog2(MAX_ARB_PORTS);
    typedef struct packed {
        logic       Valid;
        logic       SoP;
        logic       EoP;
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic [7:0] Data;
    } UART_PACKET;
    typedef enum logic {IDLE, STREAM} ARB_STATE;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: round-robin one-hot pick, searching from last_i+1 with wraparound
module rr_picker
    import Structures::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]           req_i,
    input  logic [ARB_IDX_W-1:0]   last_i,
    output logic [N-1:0]           grant_o,
    output logic                   found_o
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    int idx;
    always_comb begin
        grant_o = '0;
        found_o = 1'b0;
        idx = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_i) + k) % N;
            if (!found_o && req_i[idx[IW-1:0]]) begin
                grant_o[idx[IW-1:0]] = 1'b1;
                found_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_packet_arbiter.sv
// uart_packet_arbiter: packet-locked round-robin mux of requester beats into one registered tx stream
module uart_packet_arbiter
    import Structures::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic                 ipClk,
    input  logic                 ipReset,
    input  UART_PACKET           ipStream [NUM_PORTS],
    output logic [NUM_PORTS-1:0] opReady,
    output UART_PACKET           opTxStream,
    input  logic                 ipTxReady,
    output logic [NUM_PORTS-1:0] opGrant,
    output logic                 opBusy,
    output logic                 opDropped
);
    localparam logic [ARB_IDX_W-1:0] LAST_INIT = ARB_IDX_W'(NUM_PORTS - 1);
    ARB_STATE                 state_q, state_d;
    logic [NUM_PORTS-1:0]     grant_q, grant_d;
    logic [ARB_IDX_W-1:0]     last_q, last_d;
    UART_PACKET               tx_q, tx_d;
    logic [NUM_PORTS-1:0]     sop_req, orphan_req, win, orphan_win, ready;
    logic                     win_found, orphan_found, dropped;
    logic [ARB_IDX_W-1:0]     win_idx;
    UART_PACKET               owner_beat;
    always_comb begin
        sop_req = '0;
        orphan_req = '0;
        owner_beat = '0;
        win_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sop_req[i] = ipStream[i].Valid && ipStream[i].SoP;
            orphan_req[i] = ipStream[i].Valid && !ipStream[i].SoP && !grant_q[i];
            if (grant_q[i]) owner_beat = ipStream[i];
            if (win[i]) win_idx = ARB_IDX_W'(i);
        end
    end
    rr_picker #(.N(NUM_PORTS)) u_arb (
        .req_i   (sop_req),
        .last_i  (last_q),
        .grant_o (win),
        .found_o (win_found)
    );
    // Fixed last of NUM_PORTS-1 turns the round-robin search into lowest-index-first.
    rr_picker #(.N(NUM_PORTS)) u_orphan (
        .req_i   (orphan_req),
        .last_i  (LAST_INIT),
        .grant_o (orphan_win),
        .found_o (orphan_found)
    );
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d = last_q;
        tx_d = tx_q;
        ready = '0;
        dropped = 1'b0;
        if (tx_q.Valid && ipTxReady) tx_d.Valid = 1'b0;
        if (state_q == IDLE) begin
            if (orphan_found) begin
                ready = orphan_win;
                dropped = 1'b1;
            end else if (win_found) begin
                grant_d = win;
                last_d = win_idx;
                state_d = STREAM;
            end
        end else begin
            ready = grant_q & {NUM_PORTS{!tx_q.Valid || ipTxReady}};
            if (owner_beat.Valid && |ready) begin
                tx_d = owner_beat;
                if (owner_beat.EoP) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
        end
    end
    always_ff @(posedge ipClk) begin
        if (!ipReset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q <= LAST_INIT;
            tx_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q <= last_d;
            tx_q <= tx_d;
        end
    end
    // Handshake outputs are forced low while reset is held so nothing is drained mid-reset.
    assign opReady = ipReset ? ready : '0;
    assign opDropped = ipReset && dropped;
    assign opTxStream = tx_q;
    assign opGrant = grant_q;
    assign opBusy = (state_q == STREAM);
endmodule
